// File: rtl/cla_pkg.sv
// cla_pkg: shared definitions for the pipelined carry-lookahead adder.
// Provides default sizing, the stage-count helper (returns 0 when WIDTH is
// not a multiple of BLOCK so the top can refuse to elaborate), and the
// per-stage control payload that travels alongside the skewed data.
package cla_pkg;
   localparam int WIDTH_DEF = 64;
   localparam int BLOCK_DEF = 16;
   function automatic int stage_count(input int width, input int block);
      return (block > 0 && width > 0 && width % block == 0) ? width / block : 0;
   endfunction
   // carry is the carry out of the slice this stage resolved; c_msb is the
   // carry into that slice's top bit, only meaningful in the last stage.
   typedef struct packed {
      logic valid;
      logic sub;
      logic sat;
      logic carry;
      logic c_msb;
   } stage_ctrl_t;
endpackage

// File: rtl/cla_block.sv
// cla_block: combinational BLOCK-bit carry-lookahead group.
// Ports: a, b   - slice operands (b already inverted for subtract)
//        ci     - carry into the group
//        s      - slice sum
//        co     - carry out of the group
//        c_msb  - carry into the group's most significant bit
module cla_block
   import cla_pkg::*;
#(
   parameter int BLOCK = BLOCK_DEF
) (
   input  logic [BLOCK-1:0] a,
   input  logic [BLOCK-1:0] b,
   input  logic             ci,
   output logic [BLOCK-1:0] s,
   output logic             co,
   output logic             c_msb
);
   logic [BLOCK-1:0] g;
   logic [BLOCK-1:0] p;
   logic [BLOCK:0]   c;
   logic             gg;
   logic             pp;
   // Each carry is the prefix group-generate of bits [i:0] plus the prefix
   // group-propagate of the same bits applied to ci, so no carry depends on
   // a neighbouring carry.
   always_comb begin
      g = a & b;
      p = a ^ b;
      gg = 1'b0;
      pp = 1'b1;
      c = '0;
      c[0] = ci;
      for (int i = 0; i < BLOCK; i++) begin
         gg = g[i] | (p[i] & gg);
         pp = p[i] & pp;
         c[i+1] = gg | (pp & ci);
      end
   end
   assign s     = p ^ c[BLOCK-1:0];
   assign co    = c[BLOCK];
   assign c_msb = c[BLOCK-1];
endmodule

// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: WIDTH-bit add/subtract, one BLOCK-bit lookahead group
// per pipeline stage, valid/ready on both sides, latency WIDTH/BLOCK cycles.
// Ports: clk, rst (async, active-high)
//        in_valid/in_ready, a, b, cin (add only), sub  - operand beat
//        out_valid/out_ready, sum, cout, overflow      - result beat
//        sat - only with PIPE_CLA_SAT_EN: clamp to signed max/min on overflow
module pipelined_cla_adder
   import cla_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int BLOCK = BLOCK_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
`ifdef PIPE_CLA_SAT_EN
   input  logic             sat,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);
   localparam int STAGES = stage_count(WIDTH, BLOCK);
   localparam int LAST   = STAGES - 1;

   if (STAGES == 0) begin : g_bad_cfg
      $error("pipelined_cla_adder: WIDTH must be a positive multiple of BLOCK");
   end

   stage_ctrl_t      ctrl_q [STAGES];
   stage_ctrl_t      ctrl_d [STAGES];
   logic [WIDTH-1:0] a_q    [STAGES];
   logic [WIDTH-1:0] a_d    [STAGES];
   logic [WIDTH-1:0] b_q    [STAGES];
   logic [WIDTH-1:0] b_d    [STAGES];
   logic [WIDTH-1:0] s_q    [STAGES];
   logic [WIDTH-1:0] s_d    [STAGES];
   logic [BLOCK-1:0] blk_a  [STAGES];
   logic [BLOCK-1:0] blk_b  [STAGES];
   logic [BLOCK-1:0] blk_s  [STAGES];
   logic             blk_ci [STAGES];
   logic             blk_co [STAGES];
   logic             blk_cm [STAGES];
   logic [WIDTH-1:0] b_eff;
   logic             cin_eff;
   logic             sat_in;
   logic             stall;

   // Subtraction is A + ~B + 1; cin is ignored in that mode.
   assign b_eff   = sub ? ~b : b;
   assign cin_eff = sub | cin;
`ifdef PIPE_CLA_SAT_EN
   assign sat_in  = sat;
`else
   assign sat_in  = 1'b0;
`endif

   assign out_valid = ctrl_q[LAST].valid;
   assign stall     = out_valid && !out_ready;
   assign in_ready  = !stall;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      if (k == 0) begin : g_first
         assign blk_a[k]  = a[BLOCK-1:0];
         assign blk_b[k]  = b_eff[BLOCK-1:0];
         assign blk_ci[k] = cin_eff;
      end else begin : g_next
         assign blk_a[k]  = a_q[k-1][k*BLOCK +: BLOCK];
         assign blk_b[k]  = b_q[k-1][k*BLOCK +: BLOCK];
         assign blk_ci[k] = ctrl_q[k-1].carry;
      end
      cla_block #(.BLOCK(BLOCK)) u_blk (
         .a     (blk_a[k]),
         .b     (blk_b[k]),
         .ci    (blk_ci[k]),
         .s     (blk_s[k]),
         .co    (blk_co[k]),
         .c_msb (blk_cm[k])
      );
   end

   // Global stall: every stage holds; otherwise each stage takes the one
   // above it and fills in its own sum slice.
   always_comb begin
      for (int k = 0; k < STAGES; k++) begin
         ctrl_d[k] = ctrl_q[k];
         a_d[k]    = a_q[k];
         b_d[k]    = b_q[k];
         s_d[k]    = s_q[k];
      end
      if (!stall) begin
         ctrl_d[0] = '{valid: in_valid, sub: sub, sat: sat_in, carry: blk_co[0], c_msb: blk_cm[0]};
         a_d[0]    = a;
         b_d[0]    = b_eff;
         s_d[0]    = '0;
         s_d[0][BLOCK-1:0] = blk_s[0];
         for (int k = 1; k < STAGES; k++) begin
            ctrl_d[k]       = ctrl_q[k-1];
            ctrl_d[k].carry = blk_co[k];
            ctrl_d[k].c_msb = blk_cm[k];
            a_d[k]          = a_q[k-1];
            b_d[k]          = b_q[k-1];
            s_d[k]          = s_q[k-1];
            s_d[k][k*BLOCK +: BLOCK] = blk_s[k];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < STAGES; k++) begin
            ctrl_q[k] <= '0;
            a_q[k]    <= '0;
            b_q[k]    <= '0;
            s_q[k]    <= '0;
         end
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            ctrl_q[k] <= ctrl_d[k];
            a_q[k]    <= a_d[k];
            b_q[k]    <= b_d[k];
            s_q[k]    <= s_d[k];
         end
      end
   end

   assign cout     = ctrl_q[LAST].carry;
   assign overflow = ctrl_q[LAST].carry ^ ctrl_q[LAST].c_msb;

`ifdef PIPE_CLA_SAT_EN
   localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
   // On overflow the wrapped sign is the inverse of the true sign.
   assign sum = (ctrl_q[LAST].sat && overflow) ? (s_q[LAST][WIDTH-1] ? SMAX : SMIN) : s_q[LAST];
`else
   assign sum = s_q[LAST];
`endif
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb_pipelined_cla_adder: scoreboard bench for pipelined_cla_adder (64/16).
module tb_pipelined_cla_adder;
   localparam int W = 64;
   localparam logic [W-1:0] SMAX = 64'h7FFF_FFFF_FFFF_FFFF;
   localparam logic [W-1:0] SMIN = 64'h8000_0000_0000_0000;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         cin = 1'b0;
   logic         sub = 1'b0;
   logic         sat = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] sum;
   logic         cout;
   logic         overflow;

   int   checks = 0;
   int   errors = 0;
   exp_t q[$];
   exp_t me;

   pipelined_cla_adder #(.WIDTH(64), .BLOCK(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
`ifdef PIPE_CLA_SAT_EN
      .sat       (sat),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                  input logic tc, input logic ts, input logic tsat);
      logic [W-1:0] be;
      logic         ci;
      logic [W:0]   f;
      exp_t         e;
      be = ts ? ~tb : tb;
      ci = ts ? 1'b1 : tc;
      f = {1'b0, ta} + {1'b0, be} + {{W{1'b0}}, ci};
      e.sum  = f[W-1:0];
      e.cout = f[W];
      e.ovf  = (ta[W-1] == be[W-1]) && (f[W-1] != ta[W-1]);
`ifdef PIPE_CLA_SAT_EN
      if (tsat && e.ovf) e.sum = ta[W-1] ? SMIN : SMAX;
`else
      if (tsat) e.sum = e.sum;
`endif
      return e;
   endfunction

   // Accepts push the model result; emits pop and compare in order.
   always @(negedge clk) begin
      if (!rst) begin
         if (in_valid && in_ready) q.push_back(model(a, b, cin, sub, sat));
         if (out_valid && out_ready) begin
            if (q.size() == 0) chk("stray_beat", 64'd1, 64'd0);
            else begin
               me = q.pop_front();
               chk("sum", sum, me.sum);
               chk("cout", {63'd0, cout}, {63'd0, me.cout});
               chk("overflow", {63'd0, overflow}, {63'd0, me.ovf});
            end
         end
      end
   end

   task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input logic tc, input logic ts, input logic tsat);
      int n;
      n = 0;
      a = ta; b = tb; cin = tc; sub = ts; sat = tsat; in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("accept_timeout", 64'd0, 64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_empty(input string tag);
      int n;
      n = 0;
      while (q.size() != 0 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk(tag, 64'(q.size()), 64'd0);
   endtask

   initial begin
      int n;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_sum", sum, 64'd0);
      chk("rst_cout", {63'd0, cout}, 64'd0);
      chk("rst_overflow", {63'd0, overflow}, 64'd0);
      rst = 1'b0;
      #1;
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      @(posedge clk);
      #1;

      send(64'd64, 64'd64, 1'b0, 1'b0, 1'b0);
      n = 1;
      while (!out_valid && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("latency", 64'(n), 64'd4);
      chk("sum_128", sum, 64'd128);
      wait_empty("drain_latency");

      send(64'd64, 64'd64, 1'b0, 1'b0, 1'b0);
      send(64'd1000000000, 64'd1000000000, 1'b0, 1'b0, 1'b0);
      send(64'd123, 64'd73, 1'b0, 1'b1, 1'b0);
      send(64'd73, 64'd123, 1'b1, 1'b1, 1'b0);
      send({W{1'b1}}, 64'd1, 1'b0, 1'b0, 1'b0);
      send(SMAX, 64'd1, 1'b0, 1'b0, 1'b0);
      send(SMIN, 64'd1, 1'b0, 1'b1, 1'b0);
      send(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b1, 1'b0, 1'b0);
      wait_empty("drain_directed");

      send(64'd112233, 64'd332211, 1'b0, 1'b0, 1'b0);
      send(64'd123456, 64'd654321, 1'b0, 1'b0, 1'b0);
      out_ready = 1'b0;
      send(64'd246, 64'd562, 1'b0, 1'b0, 1'b0);
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      repeat (3) begin
         chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
         chk("stall_held_sum", sum, 64'd444444);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      wait_empty("drain_stall");

      send(64'd1, 64'd2, 1'b0, 1'b0, 1'b0);
      send(64'd3, 64'd4, 1'b0, 1'b0, 1'b0);
      send(64'd5, 64'd6, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("midrst_sum", sum, 64'd0);
      q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      chk("postrst_idle", {63'd0, out_valid}, 64'd0);
      send(64'd5, 64'd7, 1'b0, 1'b0, 1'b0);
      n = 1;
      while (!out_valid && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("postrst_sum_12", sum, 64'd12);
      wait_empty("drain_rst");

`ifdef PIPE_CLA_SAT_EN
      send(SMAX, 64'd1, 1'b0, 1'b0, 1'b1);
      send(SMAX, 64'd1, 1'b0, 1'b0, 1'b0);
      send(SMIN, 64'd1, 1'b0, 1'b1, 1'b1);
      wait_empty("drain_sat");
`endif

      fork
         begin
            for (int i = 0; i < 60; i++) begin
               if ($urandom_range(0, 3) == 0) begin
                  @(posedge clk);
                  #1;
               end
               send({$urandom, $urandom}, (i % 7 == 0) ? ~64'd0 : {$urandom, $urandom},
                    1'($urandom), 1'($urandom), 1'($urandom));
            end
         end
         begin
            repeat (150) begin
               out_ready = ($urandom_range(0, 2) != 0);
               @(posedge clk);
               #1;
            end
            out_ready = 1'b1;
         end
      join
      wait_empty("drain_random");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
Parametrised, pipelined carry-lookahead adder/subtractor; successor to the team's single-cycle 64-bit combinational CLA. Splits a WIDTH-bit operation into WIDTH/BLOCK lookahead groups, one group per pipeline stage, with a valid/ready handshake on both sides. Sits in the datapath ALU as the wide add/sub unit, sustaining one operation per cycle at clock rates the flat CLA cannot meet.

Parameters:
WIDTH, 64, operand width in bits; must be an integer multiple of BLOCK, otherwise elaboration error.
BLOCK, 16, bits resolved per pipeline stage by one lookahead group.
(Derived, not overridable) STAGES = WIDTH/BLOCK; pipeline latency in cycles.

Ports:
clk  input  1  clock; all state on rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  operand beat valid.
in_ready  output  1  unit can accept a beat this cycle.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
cin  input  1  carry-in; used only when sub=0.
sub  input  1  0: A+B+cin; 1: A-B.
out_valid  output  1  result beat valid.
out_ready  input  1  downstream accepts result.
sum  output  WIDTH  result bits.
cout  output  1  carry-out (sub=1: 1 = no borrow).
overflow  output  1  two's-complement signed overflow.

Behaviour:
- Accept when in_valid && in_ready; emit when out_valid && out_ready.
- in_ready = out_ready || !out_valid (combinational). Global stall: when out_valid && !out_ready every stage holds all registers; no bubble compression.
- Stage k (0..STAGES-1) adds bit slice [k*BLOCK +: BLOCK] using carry from stage k-1 (stage 0: effective carry-in). Higher slices of A/B and lower finished sum slices travel skewed through per-stage registers.
- Subtract: effective B = ~b, effective carry-in = 1, cin ignored. Add: effective B = b, carry-in = cin.
- Latency exactly STAGES cycles from accept to out_valid with no stall; STAGES=1 gives one registered cycle. Throughput 1 beat/cycle.
- cout = carry out of MSB group. overflow = carry into MSB XOR carry out of MSB.
- Wrap-around: sum is modulo 2^WIDTH; no saturation without optional feature.
- Per-stage valid bit; a stage register loads only when not stalled; empty stages carry valid=0 and their data is don't-care but must not be X after reset.
- Reset (any time, including mid-operation): all stage valids 0, all data registers 0; out_valid=0, sum=0, cout=0, overflow=0; in_ready=1 after reset. In-flight beats are discarded.
- Simultaneous accept and emit in the same cycle is legal and loses nothing.
- Inputs sampled only on accept; a/b/cin/sub may change freely otherwise.

Optional Feature:
Macro PIPE_CLA_SAT_EN. Defined: adds input port sat (1 bit, sampled with operands, carried down the pipeline); when sat=1 and overflow=1 the output sum is clamped to signed max (0111..1) if the true result is positive, signed min (1000..0) if negative; overflow still reports 1; cout unchanged. Not defined: no sat port, no saturation logic, pure wrap-around.

Decomposition:
- Package cla_pkg: BLOCK default, stage-count function (with divisibility check), localparams for signed max/min patterns, a struct/typedef for the per-stage payload (valid, sub, sat, carry, partial sum, remaining operands).
- Sub-module cla_block: combinational BLOCK-bit lookahead group (generate/propagate, group carry, sum, carry-out, carry into MSB); instantiated once per stage.

Test Plan:
- WIDTH=64, BLOCK=16, add 64+64, cin=0 -> after 4 cycles sum=128, cout=0, overflow=0; back-to-back 1000000000+1000000000 next cycle -> sum=2000000000 one cycle later.
- sub=1, a=123, b=73 -> sum=50, cout=1; a=73, b=123 -> sum=2^64-50, cout=0.
- a=all ones, b=1, cin=0 -> sum=0, cout=1, overflow=0 (carry ripples across all 4 stages); a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> sum=0x8000_0000_0000_0000, overflow=1.
- Stream 112233+332211, 123456+654321, 246+562 with out_ready held low 3 cycles mid-stream -> in_ready drops, results 444444, 777777, 808 emitted in order, none lost or duplicated.
- Assert rst while 3 beats in flight -> out_valid low same cycle, no stale beat emerges after release; next beat 5+7 -> sum=12.
- PIPE_CLA_SAT_EN defined, sat=1, 0x7FFF_FFFF_FFFF_FFFF+1 -> sum=0x7FFF_FFFF_FFFF_FFFF, overflow=1; sat=0 same operands -> wraps to 0x8000_0000_0000_0000.
